// File: rtl/uart_alu_cmd_ctrl.sv
// -----------------------------------------------------------------------------
// uart_alu_cmd_ctrl
//   Command controller that sits between uart_rx/uart_tx and the combinational
//   ALU. It decodes command bytes and assembles the N-bit operands A/B and the
//   opcode. On a result request it returns the ALU result over TX, LSB byte
//   first. If any operand or the opcode has not been loaded yet, it returns a
//   single NAK byte instead.
//
// Ports
//   clk           in   1     system clock, rising edge
//   rst           in   1     asynchronous reset, active low
//   i_data_rx     in   8     received byte, valid with i_rx_valid
//   i_rx_valid    in   1     one-cycle pulse, new byte on i_data_rx
//   i_tx_done     in   1     one-cycle pulse, uart_tx finished its byte
//   i_alu_result  in   N     ALU result for the current o_A/o_B/o_op
//   o_A           out  N     committed operand A
//   o_B           out  N     committed operand B
//   o_op          out  OP_W  committed opcode
//   o_tx_data     out  8     byte for uart_tx, held until i_tx_done
//   o_tx_start    out  1     one-cycle pulse, start sending o_tx_data
//   o_err         out  1     one-cycle pulse, unknown command or timeout
// -----------------------------------------------------------------------------
module uart_alu_cmd_ctrl #(
  parameter int         N       = 16,
  parameter int         OP_W    = 6,
  parameter logic [7:0] CMD_A   = 8'h01,
  parameter logic [7:0] CMD_B   = 8'h02,
  parameter logic [7:0] CMD_OP  = 8'h03,
  parameter logic [7:0] CMD_R   = 8'h04,
  parameter logic [7:0] NAK     = 8'hEE,
  parameter int         TIMEOUT = 50000
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [7:0]      i_data_rx,
  input  logic            i_rx_valid,
  input  logic            i_tx_done,
  input  logic [N-1:0]    i_alu_result,
  output logic [N-1:0]    o_A,
  output logic [N-1:0]    o_B,
  output logic [OP_W-1:0] o_op,
  output logic [7:0]      o_tx_data,
  output logic            o_tx_start,
  output logic            o_err
);

  localparam int BYTES = N / 8;
  localparam int CNT_W = $clog2(BYTES + 1);
  localparam int TMO_W = $clog2(TIMEOUT);
  localparam logic [CNT_W-1:0] LAST_BYTE = CNT_W'(BYTES - 1);
  localparam logic [TMO_W-1:0] TMO_MAX   = TMO_W'(TIMEOUT - 1);

  typedef enum logic [2:0] {IDLE, LOAD_A, LOAD_B, LOAD_OP, SEND, WAIT_DONE} state_t;

  state_t            state, state_n;
  logic [N-1:0]      shadow, shadow_n, merged;
  logic [N-1:0]      a_n, b_n;
  logic [OP_W-1:0]   op_n;
  logic              fa, fb, fop, fa_n, fb_n, fop_n;
  logic [CNT_W-1:0]  byte_cnt, byte_cnt_n;
  logic [TMO_W-1:0]  tmo, tmo_n;
  logic [N-1:0]      tx_shift, tx_shift_n;
  logic [CNT_W-1:0]  tx_cnt, tx_cnt_n;
  logic [7:0]        tx_data_n;
  logic              tx_start_n, err_n;

  // Next-state and next-output logic. Every register has a "next" value
  // here, so all outputs come straight from flops.
  always_comb begin
    state_n    = state;
    shadow_n   = shadow;
    a_n        = o_A;
    b_n        = o_B;
    op_n       = o_op;
    fa_n       = fa;
    fb_n       = fb;
    fop_n      = fop;
    byte_cnt_n = byte_cnt;
    tmo_n      = tmo;
    tx_shift_n = tx_shift;
    tx_cnt_n   = tx_cnt;
    tx_data_n  = o_tx_data;
    tx_start_n = 1'b0;
    err_n      = 1'b0;

    // The operand being assembled, with the incoming byte placed at byte_cnt.
    // The last byte is merged here directly, so the committed operand is
    // updated on the same edge that captures that byte.
    merged = shadow;
    for (int i = 0; i < BYTES; i++) begin
      if (byte_cnt == CNT_W'(i)) merged[i*8 +: 8] = i_data_rx;
    end

    case (state)
      IDLE: begin
        if (i_rx_valid) begin
          byte_cnt_n = '0;
          tmo_n      = '0;
          case (i_data_rx)
            CMD_A:  state_n = LOAD_A;
            CMD_B:  state_n = LOAD_B;
            CMD_OP: state_n = LOAD_OP;
            CMD_R: begin
              // Snapshot the result so later operand loads cannot corrupt
              // a transfer that is already in progress.
              if (fa && fb && fop) begin
                tx_shift_n = i_alu_result;
                tx_cnt_n   = CNT_W'(BYTES);
              end else begin
                tx_shift_n = N'(NAK);
                tx_cnt_n   = CNT_W'(1);
              end
              state_n = SEND;
            end
            default: err_n = 1'b1;
          endcase
        end
      end

      LOAD_A, LOAD_B, LOAD_OP: begin
        // A received byte takes priority over a timeout in the same cycle.
        if (i_rx_valid) begin
          tmo_n = '0;
          if (state == LOAD_OP) begin
            op_n    = i_data_rx[OP_W-1:0];
            fop_n   = 1'b1;
            state_n = IDLE;
          end else if (byte_cnt == LAST_BYTE) begin
            if (state == LOAD_A) begin
              a_n  = merged;
              fa_n = 1'b1;
            end else begin
              b_n  = merged;
              fb_n = 1'b1;
            end
            state_n = IDLE;
          end else begin
            shadow_n   = merged;
            byte_cnt_n = byte_cnt + CNT_W'(1);
          end
        end else if (tmo == TMO_MAX) begin
          err_n   = 1'b1;
          state_n = IDLE;
        end else begin
          tmo_n = tmo + TMO_W'(1);
        end
      end

      SEND: begin
        tx_data_n  = tx_shift[7:0];
        tx_start_n = 1'b1;
        state_n    = WAIT_DONE;
      end

      WAIT_DONE: begin
        if (i_tx_done) begin
          tx_shift_n = tx_shift >> 8;
          tx_cnt_n   = tx_cnt - CNT_W'(1);
          state_n    = (tx_cnt == CNT_W'(1)) ? IDLE : SEND;
        end
      end

      default: state_n = IDLE;
    endcase
  end

  // State and output registers, cleared asynchronously.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= IDLE;
      shadow     <= '0;
      o_A        <= '0;
      o_B        <= '0;
      o_op       <= '0;
      fa         <= 1'b0;
      fb         <= 1'b0;
      fop        <= 1'b0;
      byte_cnt   <= '0;
      tmo        <= '0;
      tx_shift   <= '0;
      tx_cnt     <= '0;
      o_tx_data  <= '0;
      o_tx_start <= 1'b0;
      o_err      <= 1'b0;
    end else begin
      state      <= state_n;
      shadow     <= shadow_n;
      o_A        <= a_n;
      o_B        <= b_n;
      o_op       <= op_n;
      fa         <= fa_n;
      fb         <= fb_n;
      fop        <= fop_n;
      byte_cnt   <= byte_cnt_n;
      tmo        <= tmo_n;
      tx_shift   <= tx_shift_n;
      tx_cnt     <= tx_cnt_n;
      o_tx_data  <= tx_data_n;
      o_tx_start <= tx_start_n;
      o_err      <= err_n;
    end
  end

endmodule
